fft_frame_packer: RTL

Streaming-to-frame packer for the FFT input path. Accepts one signed time-domain audio sample per handshake and assembles `BUFFER_SIZE` samples into the flat packed frame word that the FFT top consumes as its input bitstream. It presents each completed frame on a valid/ready output and holds it stable until the FFT side accepts it. A second internal register lets the next frame fill while the current one waits.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_frame_packer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT input path.
//   SAMPLE_SIZE  bits per signed time-domain sample
//   BUFFER_SIZE  samples per FFT frame (power of two, >= 4)
//   FRAME_CNT_W  width of the emitted-frame counter
package fft_pkg;

  localparam int unsigned SAMPLE_SIZE = 16;
  localparam int unsigned BUFFER_SIZE = 8;
  localparam int unsigned FRAME_W     = SAMPLE_SIZE * BUFFER_SIZE;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic signed [SAMPLE_SIZE-1:0] sample_t;
  typedef logic signed [FRAME_W-1:0]     frame_t;

endpackage : fft_pkg

// File: rtl/fft_frame_packer.sv
// Streaming-to-frame packer: collects BUFFER_SIZE signed samples into one flat
// frame word (sample 0 in the LSBs) and presents it on a valid/ready output.
// A separate fill buffer keeps accepting samples while the output is held.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   flush         synchronous discard of the partial fill buffer
//   sample_in     signed input sample, qualified by sample_valid
//   sample_ready  combinational: fill buffer not full and no flush
//   frame_out     packed frame, stable while frame_valid is high
//   frame_valid   frame_out holds a complete frame
//   frame_ready   downstream accepts the frame
//   frame_count   frames transferred to the output since reset (wraps)
//
// Build option: FFT_FRAMER_OVERLAP_EN selects 50% frame overlap; when it is
// undefined frames are non-overlapping.
module fft_frame_packer #(
  parameter int unsigned SAMPLE_SIZE = fft_pkg::SAMPLE_SIZE,
  parameter int unsigned BUFFER_SIZE = fft_pkg::BUFFER_SIZE
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic signed [SAMPLE_SIZE-1:0]           sample_in,
  input  logic                                    sample_valid,
  output logic                                    sample_ready,
  output logic signed [BUFFER_SIZE*SAMPLE_SIZE-1:0] frame_out,
  output logic                                    frame_valid,
  input  logic                                    frame_ready,
  output logic [fft_pkg::FRAME_CNT_W-1:0]         frame_count
);

  localparam int unsigned FRAME_W = BUFFER_SIZE * SAMPLE_SIZE;
  localparam int unsigned HALF_W  = FRAME_W / 2;
  localparam int unsigned CNT_W   = $clog2(BUFFER_SIZE + 1);
  localparam int unsigned IDX_W   = $clog2(BUFFER_SIZE);
  localparam int unsigned FCNT_W  = fft_pkg::FRAME_CNT_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);
`ifdef FFT_FRAMER_OVERLAP_EN
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BUFFER_SIZE / 2);
`endif

  // Reject frame sizes the packer and the FFT cannot handle.
  if (BUFFER_SIZE < 4 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_size
    $error("fft_frame_packer: BUFFER_SIZE must be a power of two and at least 4");
  end

  logic [FRAME_W-1:0] fill_q,  fill_d;
  logic [FRAME_W-1:0] out_q,   out_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               valid_q, valid_d;
  logic [FCNT_W-1:0]  fcnt_q,  fcnt_d;

  logic               full_c;
  logic               accept_c;
  logic               xfer_c;
  logic [IDX_W-1:0]   slot_c;

  // Handshake qualifiers; flush outranks both accept and transfer.
  assign full_c       = (cnt_q == CNT_FULL);
  assign sample_ready = !full_c && !flush;
  assign accept_c     = sample_valid && sample_ready;
  assign xfer_c       = full_c && (!valid_q || frame_ready) && !flush;
  // Only meaningful while not full, where cnt fits in IDX_W bits.
  assign slot_c       = cnt_q[IDX_W-1:0];

  // Next-state logic for fill buffer, output register and counters.
  always_comb begin
    fill_d  = fill_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    fcnt_d  = fcnt_q;

    // Output handshake; a same-cycle transfer below re-asserts valid.
    if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end

    if (flush) begin
      cnt_d = '0;
    end else if (xfer_c) begin
      out_d   = fill_q;
      valid_d = 1'b1;
      fcnt_d  = fcnt_q + FCNT_W'(1);
`ifdef FFT_FRAMER_OVERLAP_EN
      // Newest half of the frame becomes the oldest half of the next one.
      fill_d[HALF_W-1:0] = fill_q[FRAME_W-1:HALF_W];
      cnt_d              = CNT_HALF;
`else
      cnt_d = '0;
`endif
    end else if (accept_c) begin
      fill_d[slot_c*SAMPLE_SIZE +: SAMPLE_SIZE] = sample_in;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      fill_q  <= fill_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign frame_out   = out_q;
  assign frame_valid = valid_q;
  assign frame_count = fcnt_q;

endmodule : fft_frame_packer
